// File: rtl/cei_ctl.sv
// ---------------------------------------------------------------------------
// cei_ctl
//   Core-side controller for the custom-engine interface (CEI). CE-class
//   instructions are staged through S/E/M/W. The opcode and operands are
//   launched to the CE, CE halt requests and global holds freeze the pipe,
//   M-stage exceptions kill in-flight work, and CE results are returned to
//   the GPR writeback port. A halt watchdog keeps a hung CE from freezing
//   the core forever.
//
// Ports
//   CLK, RESET_D1_R_N, TMODE      clock, async active-low reset, test mode
//   DEC_CEOP_VLD/OP/INSTM32_N/RD  decoded CE instruction (enters S)
//   RF_AOP_S, RF_BOP_S            operands, valid while the op sits in S
//   PIPE_HOLD                     non-CE pipeline hold
//   XCPN_M                        exception on the M-stage instruction
//   CEI_OP_S_R, CEI_INSTM32_S_R_N registered S opcode / encoding flag
//   CEI_AOP_E_R, CEI_BOP_E_R      registered E operands
//   CEI_CEHOLD, CEC_STALL         pipeline frozen this cycle
//   CEI_XCPN_M                    kill of the valid M instruction
//   CE_RES_E, CE_SEL_E_R          CE result / result-ownership in E
//   CE_HALT_E_R_C                 CE stall request (OR of all bits)
//   CEC_WB_VLD_W/RD_W/DATA_W      GPR writeback
//   CEC_HALT_TO                   sticky watchdog error
// ---------------------------------------------------------------------------
module cei_ctl #(
    parameter int HALT_W   = 2,
    parameter int MAX_HALT = 64
) (
    input  logic              CLK,
    input  logic              RESET_D1_R_N,
    input  logic              TMODE,
    input  logic              DEC_CEOP_VLD,
    input  logic [11:0]       DEC_OP,
    input  logic              DEC_INSTM32_N,
    input  logic [4:0]        DEC_RD,
    input  logic [31:0]       RF_AOP_S,
    input  logic [31:0]       RF_BOP_S,
    input  logic              PIPE_HOLD,
    input  logic              XCPN_M,
    output logic [11:0]       CEI_OP_S_R,
    output logic              CEI_INSTM32_S_R_N,
    output logic [31:0]       CEI_AOP_E_R,
    output logic [31:0]       CEI_BOP_E_R,
    output logic              CEI_CEHOLD,
    output logic              CEI_XCPN_M,
    input  logic [31:0]       CE_RES_E,
    input  logic              CE_SEL_E_R,
    input  logic [HALT_W-1:0] CE_HALT_E_R_C,
    output logic              CEC_STALL,
    output logic              CEC_WB_VLD_W,
    output logic [4:0]        CEC_WB_RD_W,
    output logic [31:0]       CEC_WB_DATA_W,
    output logic              CEC_HALT_TO
);

    localparam logic [7:0] WD_LIMIT = 8'(MAX_HALT);

    // Valid/hold semantics: a stage holds a live instruction when its v_*
    // bit is set. Every stage moves together on a cycle with stall == 0
    // (advance); on a stall cycle S/E/M keep their contents and W receives
    // a bubble. A kill clears S/E/M valids regardless of stall, so the
    // killed instructions never reach W.

    // Test mode blocks the reset so scan shifting is not disturbed.
    logic rst_n;
    assign rst_n = RESET_D1_R_N | TMODE;

    // Stage valid bits
    logic v_s, v_e, v_m, v_w;

    // S stage
    logic [11:0] op_s;
    logic        instm32_n_s;
    logic [4:0]  rd_s;

    // E stage
    logic [31:0] aop_e;
    logic [31:0] bop_e;
    logic [4:0]  rd_e;

    // M stage
    logic        wb_en_m;
    logic [4:0]  rd_m;
    logic [31:0] res_m;

    // W stage
    logic        wb_en_w;
    logic [4:0]  rd_w;
    logic [31:0] data_w;

    // Watchdog
    logic [7:0]  wd_cnt;
    logic        wd_fired;
    logic        halt_to;

    // Control terms
    logic halt_raw;
    logic halt;
    logic stall;
    logic adv;
    logic kill;
    logic m_to_w;

    // A halt only matters while E holds a live instruction; once the
    // watchdog has fired the request is ignored so E can drain.
    assign halt_raw = (|CE_HALT_E_R_C) & v_e;
    assign halt     = halt_raw & ~wd_fired;
    assign stall    = PIPE_HOLD | halt;
    assign adv      = ~stall;
    assign kill     = XCPN_M & v_m;
    // M entry survives into W only on an advance without an exception.
    assign m_to_w   = adv & v_m & ~XCPN_M;

    // -----------------------------------------------------------------
    // Valid bits
    // -----------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            v_s <= 1'b0;
            v_e <= 1'b0;
            v_m <= 1'b0;
            v_w <= 1'b0;
        end else if (kill) begin
            // Kill also drops anything decoded in the same cycle.
            v_s <= 1'b0;
            v_e <= 1'b0;
            v_m <= 1'b0;
            v_w <= 1'b0;
        end else if (adv) begin
            v_s <= DEC_CEOP_VLD;
            v_e <= v_s;
            v_m <= v_e;
            v_w <= v_m & ~XCPN_M;
        end else begin
            // Stall: W bubble so a writeback is never repeated.
            v_w <= 1'b0;
        end
    end

    // -----------------------------------------------------------------
    // S stage data
    // -----------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            op_s        <= 12'd0;
            instm32_n_s <= 1'b1;
            rd_s        <= 5'd0;
        end else if (adv) begin
            op_s        <= DEC_OP;
            instm32_n_s <= DEC_INSTM32_N;
            rd_s        <= DEC_RD;
        end
    end

    // -----------------------------------------------------------------
    // E stage data
    // -----------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            aop_e <= 32'd0;
            bop_e <= 32'd0;
            rd_e  <= 5'd0;
        end else if (adv) begin
            aop_e <= RF_AOP_S;
            bop_e <= RF_BOP_S;
            rd_e  <= rd_s;
        end
    end

    // -----------------------------------------------------------------
    // M stage data. CE_SEL_E_R is only looked at here, i.e. on the
    // cycle E actually advances.
    // -----------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_m <= 1'b0;
            rd_m    <= 5'd0;
            res_m   <= 32'd0;
        end else if (adv) begin
            wb_en_m <= v_e & CE_SEL_E_R;
            rd_m    <= rd_e;
            res_m   <= CE_RES_E;
        end
    end

    // -----------------------------------------------------------------
    // W stage data. The destination/data registers only load for a real
    // GPR write, so the writeback bus stays put between writes.
    // -----------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_w <= 1'b0;
            rd_w    <= 5'd0;
            data_w  <= 32'd0;
        end else if (m_to_w) begin
            wb_en_w <= wb_en_m;
            if (wb_en_m) begin
                rd_w   <= rd_m;
                data_w <= res_m;
            end
        end
    end

    // -----------------------------------------------------------------
    // Halt watchdog. Counts consecutive halted cycles of the E
    // instruction; on reaching the limit the halt is masked so E can
    // advance with whatever CE_RES_E shows, and the sticky error is set.
    // -----------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt   <= 8'd0;
            wd_fired <= 1'b0;
            halt_to  <= 1'b0;
        end else if (kill || adv) begin
            wd_cnt   <= 8'd0;
            wd_fired <= 1'b0;
        end else if (halt_raw && !wd_fired) begin
            wd_cnt <= wd_cnt + 8'd1;
            if (wd_cnt + 8'd1 == WD_LIMIT) begin
                wd_fired <= 1'b1;
                halt_to  <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------
    assign CEI_OP_S_R        = op_s;
    assign CEI_INSTM32_S_R_N = instm32_n_s;
    assign CEI_AOP_E_R       = aop_e;
    assign CEI_BOP_E_R       = bop_e;
    assign CEI_CEHOLD        = stall;
    assign CEC_STALL         = stall;
    assign CEI_XCPN_M        = kill;
    assign CEC_WB_VLD_W      = v_w & wb_en_w;
    assign CEC_WB_RD_W       = rd_w;
    assign CEC_WB_DATA_W     = data_w;
    assign CEC_HALT_TO       = halt_to;

endmodule

// File: tb/tb_cei_ctl.sv
// ---------------------------------------------------------------------------
// tb_cei_ctl
//   Bench for cei_ctl (MAX_HALT = 4): reset values, a per-cycle vector
//   table (single op, CE halt, no-result op, PIPE_HOLD), hand sequences for
//   exception kill, watchdog and async reset, then random traffic checked
//   against an in-order writeback queue built from the decoded operations.
// ---------------------------------------------------------------------------
module tb_cei_ctl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tmode;
  logic        dec_vld;
  logic [11:0] dec_op;
  logic        dec_instm;
  logic [4:0]  dec_rd;
  logic [31:0] rf_a, rf_b;
  logic        pipe_hold;
  logic        xcpn;
  logic [11:0] cei_op;
  logic        cei_instm;
  logic [31:0] cei_aop, cei_bop;
  logic        cei_hold;
  logic        cei_xcpn;
  logic [31:0] ce_res;
  logic        ce_sel;
  logic [1:0]  ce_halt;
  logic        cec_stall;
  logic        wb_vld;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        halt_to;

  // CE model: either driven directly, or result = A + B and the CE owns a
  // GPR result when B is even.
  logic        ce_auto;
  logic [31:0] ce_res_drv;
  logic        ce_sel_drv;
  assign ce_res = ce_auto ? (cei_aop + cei_bop) : ce_res_drv;
  assign ce_sel = ce_auto ? ~cei_bop[0] : ce_sel_drv;

  cei_ctl #(.HALT_W(2), .MAX_HALT(4)) dut (
    .CLK(clk), .RESET_D1_R_N(rst_n), .TMODE(tmode),
    .DEC_CEOP_VLD(dec_vld), .DEC_OP(dec_op), .DEC_INSTM32_N(dec_instm),
    .DEC_RD(dec_rd), .RF_AOP_S(rf_a), .RF_BOP_S(rf_b),
    .PIPE_HOLD(pipe_hold), .XCPN_M(xcpn),
    .CEI_OP_S_R(cei_op), .CEI_INSTM32_S_R_N(cei_instm),
    .CEI_AOP_E_R(cei_aop), .CEI_BOP_E_R(cei_bop),
    .CEI_CEHOLD(cei_hold), .CEI_XCPN_M(cei_xcpn),
    .CE_RES_E(ce_res), .CE_SEL_E_R(ce_sel), .CE_HALT_E_R_C(ce_halt),
    .CEC_STALL(cec_stall), .CEC_WB_VLD_W(wb_vld), .CEC_WB_RD_W(wb_rd),
    .CEC_WB_DATA_W(wb_data), .CEC_HALT_TO(halt_to)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " op_s"},    32'(cei_op),    32'h0);
    chk({tag, " instm_s"}, 32'(cei_instm), 32'h1);
    chk({tag, " aop_e"},   cei_aop,        32'h0);
    chk({tag, " bop_e"},   cei_bop,        32'h0);
    chk({tag, " cehold"},  32'(cei_hold),  32'h0);
    chk({tag, " stall"},   32'(cec_stall), 32'h0);
    chk({tag, " xcpn_m"},  32'(cei_xcpn),  32'h0);
    chk({tag, " wb_vld"},  32'(wb_vld),    32'h0);
    chk({tag, " wb_rd"},   32'(wb_rd),     32'h0);
    chk({tag, " wb_data"}, wb_data,        32'h0);
    chk({tag, " halt_to"}, 32'(halt_to),   32'h0);
  endtask

  task automatic idle_inputs();
    dec_vld = 1'b0; dec_op = 12'h0; dec_instm = 1'b0; dec_rd = 5'd0;
    rf_a = 32'h0; rf_b = 32'h0; pipe_hold = 1'b0; xcpn = 1'b0;
    ce_halt = 2'b00;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        dvld;
    logic [11:0] op;
    logic [4:0]  rd;
    logic [31:0] a, b;
    logic        sel;
    logic [31:0] res;
    logic [1:0]  halt;
    logic        hold;
    logic        e_hold;
    logic        e_wbv;
    logic        chk_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        chk_e;
    logic [31:0] e_aop;
    logic        chk_s;
    logic [11:0] e_op;
  } vec_t;

  function automatic vec_t mk(
      input logic dvld, input logic [11:0] op, input logic [4:0] rd,
      input logic [31:0] a, input logic [31:0] b,
      input logic sel, input logic [31:0] res,
      input logic [1:0] halt, input logic hold,
      input logic e_hold, input logic e_wbv,
      input logic chk_wb, input logic [4:0] e_rd, input logic [31:0] e_data,
      input logic chk_e, input logic [31:0] e_aop,
      input logic chk_s, input logic [11:0] e_op);
    vec_t v;
    v.dvld = dvld; v.op = op; v.rd = rd; v.a = a; v.b = b; v.sel = sel;
    v.res = res; v.halt = halt; v.hold = hold; v.e_hold = e_hold;
    v.e_wbv = e_wbv; v.chk_wb = chk_wb; v.e_rd = e_rd; v.e_data = e_data;
    v.chk_e = chk_e; v.e_aop = e_aop; v.chk_s = chk_s; v.e_op = e_op;
    return v;
  endfunction

  vec_t tbl [0:22];

  // ---------------- random-phase state ----------------
  logic [36:0] exp_q[$];
  logic [36:0] got;

  initial begin
    #500000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    // -------- reset --------
    rst_n = 1'b0; tmode = 1'b0; ce_auto = 1'b0; ce_res_drv = 32'h0; ce_sel_drv = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // -------- table-driven sequences --------
    //          dvld op      rd a      b      sel res           halt  hold eh wbv cwb rd  data    ce aop    cs op
    tbl[0]  = mk(1, 12'h0A3, 7, 0,     0,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     0, 0);
    tbl[1]  = mk(0, 0,       0, 5,     3,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     1, 12'h0A3);
    tbl[2]  = mk(0, 0,       0, 0,     0,     1, 8,            2'b00, 0,  0, 0,  0,  0, 0,      1, 5,     0, 0);
    tbl[3]  = mk(0, 0,       0, 0,     0,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     0, 0);
    tbl[4]  = mk(0, 0,       0, 0,     0,     0, 0,            2'b00, 0,  0, 1,  1,  7, 8,      0, 0,     0, 0);
    tbl[5]  = mk(0, 0,       0, 0,     0,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     0, 0);
    tbl[6]  = mk(1, 12'h1B2, 9, 0,     0,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     0, 0);
    tbl[7]  = mk(0, 0,       0, 'h11,  'h22,  0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     1, 12'h1B2);
    tbl[8]  = mk(0, 12'hFFF, 0, 0,     0,     1, 'h33,         2'b01, 0,  1, 0,  0,  0, 0,      1, 'h11,  1, 0);
    tbl[9]  = mk(0, 12'hFFF, 0, 0,     0,     1, 'h33,         2'b01, 0,  1, 0,  0,  0, 0,      1, 'h11,  1, 0);
    tbl[10] = mk(0, 12'hFFF, 0, 0,     0,     1, 'h33,         2'b01, 0,  1, 0,  0,  0, 0,      1, 'h11,  1, 0);
    tbl[11] = mk(0, 0,       0, 0,     0,     1, 'h33,         2'b00, 0,  0, 0,  0,  0, 0,      1, 'h11,  1, 0);
    tbl[12] = mk(0, 0,       0, 0,     0,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     0, 0);
    tbl[13] = mk(0, 0,       0, 0,     0,     0, 0,            2'b00, 0,  0, 1,  1,  9, 'h33,   0, 0,     0, 0);
    tbl[14] = mk(0, 0,       0, 0,     0,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     0, 0);
    tbl[15] = mk(1, 12'h2C4, 3, 0,     0,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     0, 0);
    tbl[16] = mk(0, 0,       0, 1,     1,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     1, 12'h2C4);
    tbl[17] = mk(0, 0,       0, 0,     0,     0, 'hDEADBEEF,   2'b00, 0,  0, 0,  0,  0, 0,      1, 1,     0, 0);
    tbl[18] = mk(0, 0,       0, 0,     0,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     0, 0);
    tbl[19] = mk(0, 0,       0, 0,     0,     0, 0,            2'b00, 0,  0, 0,  1,  9, 'h33,   0, 0,     0, 0);
    tbl[20] = mk(0, 0,       0, 0,     0,     0, 0,            2'b00, 1,  1, 0,  0,  0, 0,      0, 0,     0, 0);
    tbl[21] = mk(0, 0,       0, 0,     0,     0, 0,            2'b01, 0,  0, 0,  0,  0, 0,      0, 0,     0, 0);
    tbl[22] = mk(0, 0,       0, 0,     0,     0, 0,            2'b00, 0,  0, 0,  0,  0, 0,      0, 0,     0, 0);

    for (int i = 0; i <= 22; i++) begin
      @(posedge clk); #1;
      dec_vld = tbl[i].dvld; dec_op = tbl[i].op; dec_rd = tbl[i].rd; dec_instm = 1'b0;
      rf_a = tbl[i].a; rf_b = tbl[i].b; ce_sel_drv = tbl[i].sel; ce_res_drv = tbl[i].res;
      ce_halt = tbl[i].halt; pipe_hold = tbl[i].hold; xcpn = 1'b0;
      @(negedge clk);
      chk($sformatf("row%0d cehold", i), 32'(cei_hold), 32'(tbl[i].e_hold));
      chk($sformatf("row%0d stall", i), 32'(cec_stall), 32'(tbl[i].e_hold));
      chk($sformatf("row%0d wb_vld", i), 32'(wb_vld), 32'(tbl[i].e_wbv));
      if (tbl[i].chk_wb) begin
        chk($sformatf("row%0d wb_rd", i), 32'(wb_rd), 32'(tbl[i].e_rd));
        chk($sformatf("row%0d wb_data", i), wb_data, tbl[i].e_data);
      end
      if (tbl[i].chk_e) chk($sformatf("row%0d aop_e", i), cei_aop, tbl[i].e_aop);
      if (tbl[i].chk_s) chk($sformatf("row%0d op_s", i), 32'(cei_op), 32'(tbl[i].e_op));
    end

    // -------- exception: op1 in M, op2 in E, op3 in S, op4 decoding --------
    ce_auto = 1'b0; ce_sel_drv = 1'b1; ce_res_drv = 32'hBAD0BAD0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      dec_vld = (c <= 3) || (c == 10);
      dec_rd  = (c == 10) ? 5'd5 : 5'(c + 1);
      rf_a = 32'h10; rf_b = 32'h20;
      xcpn = (c == 3) || (c == 4);
      @(negedge clk);
      if (c == 3) chk("xcpn kill", 32'(cei_xcpn), 32'h1);
      if (c == 4) chk("xcpn no valid m", 32'(cei_xcpn), 32'h0);
      chk($sformatf("xcpn c%0d wb_vld", c), 32'(wb_vld), 32'(c == 14));
      if (c == 14) begin
        chk("xcpn next wb_rd", 32'(wb_rd), 32'd5);
        chk("xcpn next wb_data", wb_data, 32'hBAD0BAD0);
      end
    end

    // -------- watchdog: two ops, CE halts forever --------
    ce_auto = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      dec_vld = (c <= 1);
      dec_rd  = (c == 0) ? 5'd10 : 5'd11;
      if (c == 1) begin rf_a = 32'h100; rf_b = 32'h20; end
      else if (c >= 2) begin rf_a = 32'h200; rf_b = 32'h40; end
      ce_halt = (c >= 2) ? 2'b10 : 2'b00;
      @(negedge clk);
      chk($sformatf("wd c%0d cehold", c), 32'(cei_hold),
          32'(((c >= 2) && (c <= 5)) || ((c >= 7) && (c <= 10))));
      chk($sformatf("wd c%0d halt_to", c), 32'(halt_to), 32'(c >= 6));
      chk($sformatf("wd c%0d wb_vld", c), 32'(wb_vld), 32'((c == 12) || (c == 13)));
      if (c == 12) begin
        chk("wd op1 wb_rd", 32'(wb_rd), 32'd10);
        chk("wd op1 wb_data", wb_data, 32'h120);
      end
      if (c == 13) begin
        chk("wd op2 wb_rd", 32'(wb_rd), 32'd11);
        chk("wd op2 wb_data", wb_data, 32'h240);
      end
    end

    // -------- async reset mid-halt, three ops in flight --------
    for (int c = 0; c <= 3; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      dec_vld = (c <= 2);
      dec_rd  = 5'(20 + c);
      rf_a = 32'h55 + 32'(c); rf_b = 32'h2;
      ce_halt = (c >= 3) ? 2'b01 : 2'b00;
      @(negedge clk);
      if (c == 3) chk("arst pre halt", 32'(cei_hold), 32'h1);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ce_halt = 2'b00;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("arst post c%0d wb_vld", c), 32'(wb_vld), 32'h0);
    end

    // -------- random traffic against an in-order writeback queue --------
    begin
      logic        acc_last;
      logic [31:0] cur_a, cur_b, s_a, s_b;
      logic [4:0]  cur_rd;
      acc_last = 1'b1; cur_a = 0; cur_b = 0; cur_rd = 0; s_a = 0; s_b = 0;
      ce_auto = 1'b1;
      idle_inputs();
      for (int c = 0; c < 640; c++) begin
        @(posedge clk); #1;
        if (acc_last) begin
          // S now holds whatever was presented last cycle.
          s_a = cur_a; s_b = cur_b;
          if (c < 600) begin
            dec_vld = ($urandom_range(0, 3) != 0);
            cur_rd  = 5'($urandom_range(0, 31));
            cur_a   = $urandom;
            cur_b   = $urandom;
            dec_op  = 12'($urandom_range(0, 4095));
          end else begin
            dec_vld = 1'b0;
          end
          dec_rd = cur_rd;
        end
        rf_a = s_a; rf_b = s_b;
        if (c < 600) begin
          pipe_hold = ($urandom_range(0, 9) == 0);
          ce_halt   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end else begin
          pipe_hold = 1'b0;
          ce_halt   = 2'b00;
        end
        @(negedge clk);
        if (pipe_hold) chk("rnd hold forces stall", 32'(cec_stall), 32'h1);
        chk("rnd cehold eq stall", 32'(cei_hold), 32'(cec_stall));
        if (wb_vld) begin
          if (exp_q.size() == 0) begin
            chk("rnd unexpected wb", 32'(wb_vld), 32'h0);
          end else begin
            got = exp_q.pop_front();
            chk("rnd wb_rd", 32'(wb_rd), 32'(got[36:32]));
            chk("rnd wb_data", wb_data, got[31:0]);
          end
        end
        acc_last = ~cec_stall;
        if (acc_last && dec_vld && !cur_b[0]) exp_q.push_back({cur_rd, cur_a + cur_b});
      end
      chk("rnd queue drained", 32'(exp_q.size()), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
